// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and shared constants for the pipelined ALU
package alu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int OP_ILLEGAL_MIN = 13;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_PASS    = 4'd0,
        OP_ADD     = 4'd1,
        OP_SUB     = 4'd2,
        OP_INC     = 4'd3,
        OP_DEC     = 4'd4,
        OP_OR      = 4'd5,
        OP_XOR     = 4'd6,
        OP_AND     = 4'd7,
        OP_NOT     = 4'd8,
        OP_SHL     = 4'd9,
        OP_SHR     = 4'd10,
        OP_ACC_ADD = 4'd11,
        OP_ACC_CLR = 4'd12,
        OP_RSV13   = 4'd13,
        OP_RSV14   = 4'd14,
        OP_RSV15   = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational opcode decode, arithmetic and accumulator next-state
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] acc,
    input  alu_op_e           op,
    output logic [DATA_W:0]   res,
    output logic [DATA_W-1:0] acc_next,
    output logic              acc_we,
    output logic              err
);

    logic [DATA_W:0] ax;
    logic [DATA_W:0] bx;
    logic [DATA_W:0] accx;
    logic [DATA_W:0] acc_sum;

    assign ax      = {1'b0, a};
    assign bx      = {1'b0, b};
    assign accx    = {1'b0, acc};
    assign acc_sum = accx + ax;

    always_comb begin
        res      = '0;
        acc_next = acc;
        acc_we   = 1'b0;
        err      = 1'b0;
        case (op)
            OP_PASS:    res = ax;
            OP_ADD:     res = ax + bx;
            OP_SUB:     res = ax - bx;
            OP_INC:     res = ax + (DATA_W+1)'(1);
            OP_DEC:     res = ax - (DATA_W+1)'(1);
            OP_OR:      res = ax | bx;
            OP_XOR:     res = ax ^ bx;
            OP_AND:     res = ax & bx;
            OP_NOT:     res = {1'b0, ~a};
            OP_SHL:     res = {a, 1'b0};
            OP_SHR:     res = {2'b00, a[DATA_W-1:1]};
            OP_ACC_ADD: begin
                res      = acc_sum;
                acc_next = acc_sum[DATA_W-1:0];
                acc_we   = 1'b1;
            end
            OP_ACC_CLR: begin
                acc_next = '0;
                acc_we   = 1'b1;
            end
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with accumulator and status flags
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [OP_W-1:0]   op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   result,
    output logic              zero,
    output logic              err
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [OP_W-1:0]   s1_op;
    logic              s2_valid;
    logic              s2_ready;
    logic [DATA_W-1:0] acc;

    logic [DATA_W:0]   core_res;
    logic [DATA_W-1:0] core_acc_next;
    logic              core_acc_we;
    logic              core_err;
    logic              op_hi_bad;
    logic [DATA_W:0]   s1_res;
    logic              s1_err;
    logic              s1_xfer;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign s1_xfer   = s1_valid && s2_ready;
    assign out_valid = s2_valid;

    // Opcode bits above the 4-bit encoding make the op illegal when OP_W is widened.
    generate
        if (OP_W > ALU_OP_W) begin : g_wide_op
            assign op_hi_bad = |s1_op[OP_W-1:ALU_OP_W];
        end else begin : g_narrow_op
            assign op_hi_bad = 1'b0;
        end
    endgenerate

    alu_core #(.DATA_W(DATA_W)) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .acc      (acc),
        .op       (alu_op_e'(s1_op[ALU_OP_W-1:0])),
        .res      (core_res),
        .acc_next (core_acc_next),
        .acc_we   (core_acc_we),
        .err      (core_err)
    );

    assign s1_res = op_hi_bad ? '0 : core_res;
    assign s1_err = op_hi_bad || core_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            err      <= 1'b0;
            acc      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_a  <= a_in;
                s1_b  <= b_in;
                s1_op <= op;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            // acc moves with the op leaving stage 1, so a following ACC_ADD in stage 1 sees it next cycle.
            if (s1_xfer) begin
                result <= s1_res;
                zero   <= ~|s1_res[DATA_W-1:0];
                err    <= s1_err;
                if (core_acc_we && !op_hi_bad) begin
                    acc <= core_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] result;
    logic       zero;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [8:0] sweep_exp [0:10];
    logic [8:0] acc_exp   [0:3];

    alu_pipe #(.DATA_W(8), .OP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] o, input logic [8:0] er, input logic ez,
                         input logic ee);
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        op       = o;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
        op       = 4'($urandom);
        chk({tag, "_latency"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_err"}, err, ee);
    endtask

    initial begin
        sweep_exp = '{9'h005, 9'h008, 9'h002, 9'h006, 9'h004, 9'h007,
                      9'h006, 9'h001, 9'h0FA, 9'h00A, 9'h002};
        acc_exp   = '{9'h000, 9'h064, 9'h0C8, 9'h12C};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        op        = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // opcode sweep at full throughput
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("sweep_valid_op%0d", i - 2), out_valid, 1);
                chk($sformatf("sweep_result_op%0d", i - 2), result, sweep_exp[i-2]);
                chk($sformatf("sweep_err_op%0d", i - 2), err, 0);
            end else begin
                chk($sformatf("sweep_latency_%0d", i), out_valid, 0);
            end
            if (i < 11) begin
                in_valid = 1'b1;
                a_in     = 8'd5;
                b_in     = 8'd3;
                op       = 4'(i);
            end else begin
                in_valid = 1'b0;
            end
        end

        issue("add_wrap", 8'd200, 8'd100, 4'd1, 9'h12C, 1'b0, 1'b0);
        issue("sub_wrap", 8'd3,   8'd5,   4'd2, 9'h1FE, 1'b0, 1'b0);
        issue("dec_zero", 8'd0,   8'd0,   4'd4, 9'h1FF, 1'b0, 1'b0);
        issue("inc_wrap", 8'd255, 8'd0,   4'd3, 9'h100, 1'b1, 1'b0);

        // accumulator: clear then three back-to-back adds
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("acc_valid_%0d", i - 2), out_valid, 1);
                chk($sformatf("acc_result_%0d", i - 2), result, acc_exp[i-2]);
            end
            if (i == 0) begin
                in_valid = 1'b1;
                a_in     = 8'd0;
                op       = 4'd12;
            end else if (i < 4) begin
                in_valid = 1'b1;
                a_in     = 8'd100;
                op       = 4'd11;
            end else begin
                in_valid = 1'b0;
            end
        end
        issue("acc_final", 8'd0, 8'd0, 4'd11, 9'h02C, 1'b0, 1'b0);

        // backpressure
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in      = 8'd10;
        op        = 4'd0;
        #1 chk("bp_accept0", in_ready, 1);
        @(negedge clk);
        a_in = 8'd11;
        #1 chk("bp_accept1", in_ready, 1);
        @(negedge clk);
        a_in = 8'd12;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
            chk($sformatf("bp_valid_%0d", i), out_valid, 1);
            chk($sformatf("bp_result_%0d", i), result, 9'd10);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_drain1_valid", out_valid, 1);
        chk("bp_drain1", result, 9'd11);
        @(negedge clk);
        chk("bp_drain2_valid", out_valid, 1);
        chk("bp_drain2", result, 9'd12);
        @(negedge clk);
        chk("bp_drain_empty", out_valid, 0);

        issue("illegal14", 8'd9, 8'd0, 4'd14, 9'h000, 1'b1, 1'b1);
        issue("post_illegal", 8'd5, 8'd3, 4'd1, 9'h008, 1'b0, 1'b0);

        // reset with two transactions in flight
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 8'd77;
        op       = 4'd0;
        @(negedge clk);
        a_in = 8'd78;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid_pre_valid", out_valid, 1);
        chk("rst_mid_pre_result", result, 9'd77);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_dropped", out_valid, 0);
        issue("acc_after_rst", 8'd7, 8'd0, 4'd11, 9'h007, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
